// File: rtl/imm_decode_stage.sv
// RISC-V immediate generator between fetch and decode. It classifies each
// instruction by opcode and produces the sign-extended immediate. The stage uses
// a 2-entry skid buffer behind a registered in_ready.
module imm_decode_stage #(
    parameter int XLEN     = 32,
    parameter int RV64_OPS = 0
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // The 32-bit-word ops (OP-32, OP-IMM-32) only exist on a 64-bit datapath.
    localparam bit RV64_EN = (XLEN == 64) && (RV64_OPS != 0);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic            s_bit;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    assign s_bit = in_inst[31];
    assign imm_i = {{(XLEN-11){s_bit}}, in_inst[30:20]};
    assign imm_s = {{(XLEN-11){s_bit}}, in_inst[30:25], in_inst[11:7]};
    assign imm_b = {{(XLEN-12){s_bit}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){s_bit}}, in_inst[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){s_bit}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        dec_fmt     = FMT_ILL;
        dec_illegal = 1'b1;
        dec_imm     = '0;
        case (in_inst[6:0])
            7'b0110011: begin
                dec_fmt     = FMT_R;
                dec_illegal = 1'b0;
            end
            7'b0111011: begin
                if (RV64_EN) begin
                    dec_fmt     = FMT_R;
                    dec_illegal = 1'b0;
                end
            end
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                dec_fmt     = FMT_I;
                dec_illegal = 1'b0;
                dec_imm     = imm_i;
            end
            7'b0011011: begin
                if (RV64_EN) begin
                    dec_fmt     = FMT_I;
                    dec_illegal = 1'b0;
                    dec_imm     = imm_i;
                end
            end
            7'b0100011: begin
                dec_fmt     = FMT_S;
                dec_illegal = 1'b0;
                dec_imm     = imm_s;
            end
            7'b1100011: begin
                dec_fmt     = FMT_B;
                dec_illegal = 1'b0;
                dec_imm     = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt     = FMT_U;
                dec_illegal = 1'b0;
                dec_imm     = imm_u;
            end
            7'b1101111: begin
                dec_fmt     = FMT_J;
                dec_illegal = 1'b0;
                dec_imm     = imm_j;
            end
            default: begin
                dec_fmt     = FMT_ILL;
                dec_illegal = 1'b1;
                dec_imm     = '0;
            end
        endcase
    end

    logic            accept, drain;
    logic            load_new_main, load_skid_main, load_new_skid;

    logic [XLEN-1:0] skid_imm_reg;
    logic [2:0]      skid_fmt_reg;
    logic            skid_illegal_reg;
    logic [31:0]     skid_inst_reg;
    logic [XLEN-1:0] skid_pc_reg;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_next     = state_reg;
        load_new_main  = 1'b0;
        load_skid_main = 1'b0;
        load_new_skid  = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next    = ONE;
                        load_new_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_new_main = 1'b1;
                    end else if (accept) begin
                        state_next    = TWO;
                        load_new_skid = 1'b1;
                    end else if (drain) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_next     = ONE;
                        load_skid_main = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Registered ready: precomputed from the state being entered.
            in_ready  <= (state_next != TWO);
            out_valid <= (state_next != EMPTY);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_imm     <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
            out_inst    <= '0;
            out_pc      <= '0;
        end else if (load_new_main) begin
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_illegal <= dec_illegal;
            out_inst    <= in_inst;
            out_pc      <= in_pc;
        end else if (load_skid_main) begin
            out_imm     <= skid_imm_reg;
            out_fmt     <= skid_fmt_reg;
            out_illegal <= skid_illegal_reg;
            out_inst    <= skid_inst_reg;
            out_pc      <= skid_pc_reg;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            skid_imm_reg     <= '0;
            skid_fmt_reg     <= '0;
            skid_illegal_reg <= 1'b0;
            skid_inst_reg    <= '0;
            skid_pc_reg      <= '0;
        end else if (load_new_skid) begin
            skid_imm_reg     <= dec_imm;
            skid_fmt_reg     <= dec_fmt;
            skid_illegal_reg <= dec_illegal;
            skid_inst_reg    <= in_inst;
            skid_pc_reg      <= in_pc;
        end
    end

endmodule
